fp_add_pipe: RTL
================

// Module: fp_add_pipe
// PURPOSE
//  Pipelined, parametrised IEEE-754 adder/subtractor, successor to the combinational FP adder.
//  Handles generic EXP_W/MAN_W formats, add/sub per operation, round-to-nearest-even, special values and flags.
//  Uses a valid/ready stream on both sides. Sits in the ALU floating-point datapath between operand issue and writeback.
// PARAMETERS
//  EXP_W   8    exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W   23   stored fraction width (hidden bit implied)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              operand beat valid
//  in_ready   out  1              block accepts beat this cycle
//  a          in   1+EXP_W+MAN_W  operand A {sign,exp,frac}
//  b          in   1+EXP_W+MAN_W  operand B
//  sub        in   1              0: A+B, 1: A-B (B sign inverted)
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  sum        out  1+EXP_W+MAN_W  rounded result
//  flags      out  4              {invalid,overflow,underflow,inexact}
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, sum and flags = 0. in_ready = 1 the cycle after reset deasserts.
//  - Reset mid-operation discards all in-flight beats; no result is emitted for them.
//  - Pipeline: 3 stages, fixed latency 3 cycles from accepted beat to out_valid when unstalled.
//      S1: unpack; swap so |A|>=|B|; align the smaller significand right by exp diff.
//          Keep guard, round and sticky bits. A shift >= MAN_W+3 leaves only sticky.
//      S2: add or subtract the (MAN_W+4)-bit significands according to effective sign.
//          Result sign = sign of the larger operand.
//      S3: normalise (1-bit right on carry, leading-zero left shift on cancellation); apply RNE; renormalise on
//          rounding carry; pack.
//  - Handshake: advance = !out_valid | out_ready; in_ready = advance.
//      Beat accepted when in_valid & in_ready. Whole pipe stalls together when !advance.
//      Output held stable while out_valid & !out_ready. Bubbles propagate; no reordering; one beat per cycle max.
//  - Special values (checked in S1, carried as a bypass tag):
//      NaN operand, or inf - inf (effective) -> {0,all-ones,1,0...} quiet NaN; invalid=1 for inf-inf.
//      Invalid is also set for a signalling-NaN input.
//      inf op finite -> that inf with its effective sign.
//      Subnormal inputs flushed to signed zero (no flag).
//  - Zeros: exact cancellation -> +0. (-0)+(-0) -> -0. x+0 -> x exactly.
//  - Overflow: rounded exponent >= all-ones -> signed inf; overflow=1, inexact=1.
//  - Underflow: normalised exponent <= 0 -> signed zero (flush); underflow=1, inexact=1.
//  - inexact = any of guard/round/sticky set before rounding.
//  - Flags are per result, valid with out_valid, not sticky.
// TESTING
//  1. a=0x3F800000, b=0x40000000, sub=0 -> sum=0x40400000, flags=0, out_valid exactly 3 cycles after accept.
//  2. a=0x3F800000, b=0x3F800000, sub=1 -> sum=0x00000000 (+0), flags=0.
//  3. a=0x3F800000, b=0x33800000 (tie at 2^-24) -> sum=0x3F800000 (RNE to even), inexact=1.
//     a=0x3F800001, same b -> sum=0x3F800002, inexact=1.
//  4. a=b=0x7F7FFFFF -> sum=0x7F800000, overflow=1, inexact=1.
//     a=0x7F800000, b=0x7F800000, sub=1 -> sum=0x7FC00000, invalid=1.
//  5. Backpressure: stream 5 beats with out_ready=0 -> in_ready drops after 3 accepted.
//     Release out_ready -> results in issue order, none lost or duplicated.
//  6. Assert rst with 2 beats in flight -> out_valid=0 next cycle; no stale result after reset release.
//     Repeat tests 1-3 with EXP_W=5, MAN_W=10 (half precision): 0x3C00+0x4000 -> 0x4200.

Source files
------------

// File: rtl/fp_add_if.sv
// fp_add_if: operand and result valid/ready streams of the pipelined floating-point adder
interface fp_add_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] sum;
  logic [3:0] flags;
  modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum, flags);
  modport slave (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum, flags);
endinterface

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage IEEE-754 adder/subtractor with RNE rounding, special values and flags
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  fp_add_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  logic adv;
  assign adv = !io.out_valid | io.out_ready;
  assign io.in_ready = adv;
  logic sa, sb, za, zb, na, nb, ia, ib, swap, d_sl, d_effsub, d_byp, d_inv;
  logic [EXP_W-1:0] ea, eb, d_el, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [W-2:0] ma, mb;
  logic [SW-1:0] d_ml, ws, sh, d_sm;
  logic [W-1:0] d_bval;
  always_comb begin
    sa = io.a[W-1];
    sb = io.b[W-1] ^ io.sub;
    ea = io.a[W-2:MAN_W];
    eb = io.b[W-2:MAN_W];
    fa = io.a[MAN_W-1:0];
    fb = io.b[MAN_W-1:0];
    za = ea == '0;
    zb = eb == '0;
    ia = ea == EMAX && fa == '0;
    ib = eb == EMAX && fb == '0;
    na = ea == EMAX && fa != '0;
    nb = eb == EMAX && fb != '0;
    ma = za ? '0 : io.a[W-2:0];
    mb = zb ? '0 : io.b[W-2:0];
    swap = mb > ma;
    d_sl = swap ? sb : sa;
    d_el = swap ? eb : ea;
    diff = swap ? eb - ea : ea - eb;
    d_effsub = sa ^ sb;
    d_ml = {1'b1, swap ? fb : fa, 3'b000};
    ws = (swap ? za : zb) ? '0 : {1'b1, swap ? fa : fb, 3'b000};
    sh = ws >> diff;
    d_sm = {sh[SW-1:1], sh[0] | (|(ws & ~({SW{1'b1}} << diff)))};
    d_inv = (na & ~fa[MAN_W-1]) | (nb & ~fb[MAN_W-1]) | (ia & ib & d_effsub);
    d_byp = na | nb | ia | ib | (za & zb);
    d_bval = (na | nb | (ia & ib & d_effsub)) ? QNAN :
             ia ? {sa, EMAX, {MAN_W{1'b0}}} :
             ib ? {sb, EMAX, {MAN_W{1'b0}}} :
             {sa & sb, {(W-1){1'b0}}};
  end
  logic s1_v, s1_sign, s1_sub, s1_byp, s1_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0] s1_ml, s1_sm;
  logic [W-1:0] s1_bval;
  always_ff @(posedge clk)
    if (rst) s1_v <= 1'b0;
    else if (adv) begin
      s1_v <= io.in_valid;
      s1_sign <= d_sl;
      s1_sub <= d_effsub;
      s1_byp <= d_byp;
      s1_inv <= d_inv;
      s1_exp <= d_el;
      s1_ml <= d_ml;
      s1_sm <= d_sm;
      s1_bval <= d_bval;
    end
  logic [SW:0] d_mag;
  assign d_mag = s1_sub ? {1'b0, s1_ml} - {1'b0, s1_sm} : {1'b0, s1_ml} + {1'b0, s1_sm};
  logic s2_v, s2_sign, s2_byp, s2_inv;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0] s2_mag;
  logic [W-1:0] s2_bval;
  always_ff @(posedge clk)
    if (rst) s2_v <= 1'b0;
    else if (adv) begin
      s2_v <= s1_v;
      s2_sign <= s1_sign;
      s2_byp <= s1_byp;
      s2_inv <= s1_inv;
      s2_exp <= s1_exp;
      s2_mag <= d_mag;
      s2_bval <= s1_bval;
    end
  logic [LZW-1:0] lz;
  logic [SW-1:0] nm;
  logic [XW-1:0] ne, re;
  logic rup, ovf, unf, inx;
  logic [MAN_W+1:0] rs;
  logic [MAN_W-1:0] rf;
  logic [W-1:0] d_sum;
  logic [3:0] d_flags;
  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++) if (s2_mag[i]) lz = LZW'(SW - 1 - i);
    nm = s2_mag[SW] ? {s2_mag[SW:2], |s2_mag[1:0]} : s2_mag[SW-1:0] << lz;
    ne = s2_mag[SW] ? XW'(s2_exp) + XW'(1) : XW'(s2_exp) - XW'(lz);
    inx = |nm[2:0];
    rup = nm[2] & (nm[1] | nm[0] | nm[3]);
    rs = {1'b0, nm[SW-1:3]} + (MAN_W+2)'(rup);
    rf = rs[MAN_W+1] ? rs[MAN_W:1] : rs[MAN_W-1:0];
    re = ne + XW'(rs[MAN_W+1]);
    unf = ne[XW-1] | (ne == '0);
    ovf = !unf & (re >= XW'(EMAX));
    d_sum = s2_byp ? s2_bval :
            s2_mag == '0 ? '0 :
            unf ? {s2_sign, {(W-1){1'b0}}} :
            ovf ? {s2_sign, EMAX, {MAN_W{1'b0}}} :
            {s2_sign, re[EXP_W-1:0], rf};
    d_flags = s2_byp ? {s2_inv, 3'b000} :
              s2_mag == '0 ? 4'b0000 :
              {1'b0, ovf, unf, inx | ovf | unf};
  end
  always_ff @(posedge clk)
    if (rst) begin
      io.out_valid <= 1'b0;
      io.sum <= '0;
      io.flags <= '0;
    end else if (adv) begin
      io.out_valid <= s2_v;
      io.sum <= d_sum;
      io.flags <= d_flags;
    end
endmodule
